// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller.
// Holds the roll FSM state enum, the face range, the 7-segment patterns
// ({g,f,e,d,c,b,a}, active-high) and the face-to-segment decoder.
package dice_pkg;

  localparam int unsigned RND_W  = 8;
  localparam int unsigned FACE_W = 3;
  localparam int unsigned SEG_W  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ANIM   = 2'd1,
    REDUCE = 2'd2
  } state_t;

  localparam logic [FACE_W-1:0] FACE_MIN = 3'd1;
  localparam logic [FACE_W-1:0] FACE_MAX = 3'd6;

  localparam logic [SEG_W-1:0] SEG_FACE1 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_FACE2 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_FACE3 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_FACE4 = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_FACE5 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_FACE6 = 7'b1111101;

  // Map a face 1..6 to its segment pattern; out-of-range faces show face 1.
  function automatic logic [SEG_W-1:0] face_to_seg(input logic [FACE_W-1:0] face);
    logic [SEG_W-1:0] s;
    case (face)
      3'd2:    s = SEG_FACE2;
      3'd3:    s = SEG_FACE3;
      3'd4:    s = SEG_FACE4;
      3'd5:    s = SEG_FACE5;
      3'd6:    s = SEG_FACE6;
      default: s = SEG_FACE1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dice_roller_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and rising-edge
// detector.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   btn   - raw asynchronous, bouncy button
//   level - debounced button level
//   rise  - one-cycle pulse in the cycle after level goes high
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronised input disagrees with the
  // debounced level; any agreement restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Six-sided die: debounced button press -> tumble animation -> modulo-6
// reduction of one latched random byte.
// Ports:
//   clk  - 50 MHz system clock
//   rst  - synchronous active-high reset
//   btn  - raw roll button (active-high, bouncy)
//   rnd  - free-running random byte
//   dice - current face 1..6
//   busy - high while animating or reducing
//   done - one-cycle pulse when a new result is written
//   seg  - 7-segment pattern of dice; only when DICE_SEG_EN is defined
module dice_roller
  import dice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned ANIM_STEPS       = 8,
  parameter int unsigned ANIM_STEP_CYCLES = 2_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic [RND_W-1:0]  rnd,
  output logic [FACE_W-1:0] dice,
  output logic              busy,
  output logic              done
`ifdef DICE_SEG_EN
  ,
  output logic [SEG_W-1:0]  seg
`endif
);

  localparam int unsigned CYC_W  = (ANIM_STEP_CYCLES > 1) ? $clog2(ANIM_STEP_CYCLES) : 1;
  localparam int unsigned STEP_W = (ANIM_STEPS > 1) ? $clog2(ANIM_STEPS) : 1;
  localparam logic [RND_W-1:0] SIX = 8'd6;

  logic press;
  logic level;

  state_t             state, state_nxt;
  logic [CYC_W-1:0]   cyc_cnt, cyc_nxt;
  logic [STEP_W-1:0]  step_cnt, step_nxt;
  logic [RND_W-1:0]   acc, acc_nxt;
  logic [FACE_W-1:0]  dice_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .level(level),
    .rise (press)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      step_cnt <= '0;
      acc      <= '0;
      dice     <= FACE_MIN;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cyc_cnt  <= cyc_nxt;
      step_cnt <= step_nxt;
      acc      <= acc_nxt;
      dice     <= dice_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next state, counters, reducer and face.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    step_nxt  = step_cnt;
    acc_nxt   = acc;
    dice_nxt  = dice;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (press) begin
          state_nxt = ANIM;
          cyc_nxt   = '0;
          step_nxt  = '0;
        end
      end

      ANIM: begin
        if (cyc_cnt == CYC_W'(ANIM_STEP_CYCLES - 1)) begin
          cyc_nxt  = '0;
          dice_nxt = (dice == FACE_MAX) ? FACE_MIN : dice + FACE_W'(1);
          if (step_cnt == STEP_W'(ANIM_STEPS - 1)) begin
            state_nxt = REDUCE;
            acc_nxt   = rnd;
          end else begin
            step_nxt = step_cnt + STEP_W'(1);
          end
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end

      // Repeated subtraction: acc below 6 is the remainder.
      REDUCE: begin
        if (acc >= SIX) begin
          acc_nxt = acc - SIX;
        end else begin
          dice_nxt  = acc[FACE_W-1:0] + FACE_W'(1);
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

`ifdef DICE_SEG_EN
  // Segment register tracks the face register edge for edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_FACE1;
    end else begin
      seg <= face_to_seg(dice_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller with small timing parameters.
module tb_dice_roller;

  localparam int unsigned DB  = 4;
  localparam int unsigned AS  = 3;
  localparam int unsigned ASC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [7:0] rnd;
  logic [2:0] dice;
  logic       busy;
  logic       done;
`ifdef DICE_SEG_EN
  logic [6:0] seg;
`endif

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int last_face = 1;

  dice_roller #(
    .DEBOUNCE_CYCLES (DB),
    .ANIM_STEPS      (AS),
    .ANIM_STEP_CYCLES(ASC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .rnd (rnd),
    .dice(dice),
    .busy(busy),
    .done(done)
`ifdef DICE_SEG_EN
    ,
    .seg (seg)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit hit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_seg(input int face);
    case (face)
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Model: face after a roll of byte r.
  function automatic int roll_face(input int r);
    return (r % 6) + 1;
  endfunction

  // Model: cycles from ANIM entry to the done edge.
  function automatic int roll_cycles(input int r);
    return AS * ASC + r / 6 + 1;
  endfunction

  // Raise btn and return the edge index (0 = first sampling edge) at which busy rose.
  task automatic press_catch(output int edge_idx);
    edge_idx = -1;
    btn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        edge_idx = i;
        break;
      end
    end
  endtask

  // Cycles until done is observed; -1 if it never comes.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic settle();
    btn = 1'b0;
    repeat (DB + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0; rnd = 8'd0;
    repeat (3) @(negedge clk);
    total++; if (dice !== 3'd1) begin bad++; $display("FAIL reset_dice got=%0d exp=1", dice); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef DICE_SEG_EN
    total++; if (seg !== 7'b0000110) begin bad++; $display("FAIL reset_seg got=%b exp=0000110", seg); end
`endif
    rst = 1'b0;
    @(negedge clk);
    last_face = 1;
  endtask

  task automatic test_clean_press();
    int e, red, d0, expf;
    rnd = 8'd255;
    d0 = done_seen;
    press_catch(e);
    total++; if (e != DB + 3) begin bad++; $display("FAIL press_latency got=%0d exp=%0d", e, DB + 3); end
    for (int i = 1; i <= AS * ASC; i++) begin
      @(negedge clk);
      expf = ((last_face - 1 + i / ASC) % 6) + 1;
      total++; if (dice !== 3'(expf)) begin bad++; $display("FAIL anim_face i=%0d got=%0d exp=%0d", i, dice, expf); end
    end
    wait_done(red);
    total++; if (red != 255 / 6 + 1) begin bad++; $display("FAIL reduce_len got=%0d exp=%0d", red, 255 / 6 + 1); end
    total++; if (dice !== 3'd4) begin bad++; $display("FAIL clean_face got=%0d exp=4", dice); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clean_busy_low got=%b exp=0", busy); end
`ifdef DICE_SEG_EN
    total++; if (seg !== 7'b1100110) begin bad++; $display("FAIL clean_seg got=%b exp=1100110", seg); end
`endif
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", done); end
    repeat (20) @(negedge clk);
    settle();
    total++; if (done_seen - d0 != 1) begin bad++; $display("FAIL hold_one_roll got=%0d exp=1", done_seen - d0); end
    last_face = 4;
  endtask

  // One full roll of byte r, checked against the model.
  task automatic test_roll(input int r, input string tag);
    int e, c;
    rnd = 8'(r);
    press_catch(e);
    btn = 1'b0;
    wait_done(c);
    total++; if (c != roll_cycles(r)) begin bad++; $display("FAIL %s_len r=%0d got=%0d exp=%0d", tag, r, c, roll_cycles(r)); end
    total++; if (dice !== 3'(roll_face(r))) begin bad++; $display("FAIL %s_face r=%0d got=%0d exp=%0d", tag, r, dice, roll_face(r)); end
`ifdef DICE_SEG_EN
    total++; if (seg !== exp_seg(roll_face(r))) begin bad++; $display("FAIL %s_seg r=%0d got=%b exp=%b", tag, r, seg, exp_seg(roll_face(r))); end
`endif
    last_face = roll_face(r);
    settle();
  endtask

  task automatic test_boundary();
    test_roll(0, "mod0");
    test_roll(5, "mod5");
    test_roll(6, "mod6");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) test_roll(int'($urandom_range(0, 255)), "rand");
  endtask

  task automatic test_latch();
    int e, c;
    rnd = 8'd17;
    press_catch(e);
    btn = 1'b0;
    repeat (AS * ASC) @(negedge clk);
    rnd = 8'd200;
    wait_done(c);
    total++; if (c != 17 / 6 + 1) begin bad++; $display("FAIL latch_len got=%0d exp=%0d", c, 17 / 6 + 1); end
    total++; if (dice !== 3'(roll_face(17))) begin bad++; $display("FAIL latch_face got=%0d exp=%0d", dice, roll_face(17)); end
    last_face = roll_face(17);
    settle();
  endtask

  task automatic test_bounce();
    int hits = 0;
    btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      repeat (2) begin
        @(negedge clk);
        if (busy !== 1'b0) hits++;
      end
    end
    btn = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0) hits++;
    end
    total++; if (hits != 0) begin bad++; $display("FAIL bounce_busy got=%0d busy cycles exp=0", hits); end
  endtask

  task automatic test_repress();
    int e, c, d0, late = 0;
    rnd = 8'd255;
    d0 = done_seen;
    press_catch(e);
    btn = 1'b0;
    repeat (7) @(negedge clk);
    btn = 1'b1;
    repeat (20) @(negedge clk);
    btn = 1'b0;
    wait_done(c);
    total++; if (c < 0) begin bad++; $display("FAIL repress_done got=timeout exp=done"); end
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) late++;
    end
    total++; if (done_seen - d0 != 1) begin bad++; $display("FAIL repress_count got=%0d exp=1", done_seen - d0); end
    total++; if (late != 0) begin bad++; $display("FAIL repress_queued got=%0d busy cycles exp=0", late); end
    last_face = roll_face(255);
  endtask

  task automatic test_reset_mid();
    int e, d0;
    rnd = 8'd255;
    d0 = done_seen;
    press_catch(e);
    btn = 1'b0;
    repeat (AS * ASC + 9) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_pre_busy got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (dice !== 3'd1) begin bad++; $display("FAIL midreset_dice got=%0d exp=1", dice); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", done); end
`ifdef DICE_SEG_EN
    total++; if (seg !== 7'b0000110) begin bad++; $display("FAIL midreset_seg got=%b exp=0000110", seg); end
`endif
    rst = 1'b0;
    repeat (60) @(negedge clk);
    total++; if (done_seen != d0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", done_seen - d0); end
    last_face = 1;
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; rnd = 8'd0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_boundary();
    test_latch();
    test_random();
    test_bounce();
    test_repress();
    settle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
# dice_roller

Consumes the free-running 8-bit LFSR random byte `rnd` and turns a push-button press into a fair-looking six-sided die roll. It has three stages: button debounce, a short "tumbling" animation, then reduction of one sampled `rnd` value modulo 6. The held result drives the board LEDs, and optionally a 7-segment digit. It sits directly downstream of the random-number generator, in the same 50 MHz `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before the debounced button level changes (20 ms at 50 MHz).
- `ANIM_STEPS`, default 8: number of tumble steps shown before the result.
- `ANIM_STEP_CYCLES`, default 2_500_000: cycles per tumble step (50 ms).
- `clk`  in  1  50 MHz system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `btn`  in  1  raw roll button, active-high, asynchronous and bouncy.
- `rnd`  in  8  random byte from the generator; may change on any cycle.
- `dice`  out  3  current face, 1..6 (values 0 and 7 are never driven).
- `busy`  out  1  high while in ANIM or REDUCE.
- `done`  out  1  one-cycle pulse when a new result is written.
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active-high; present only with `DICE_SEG_EN`.

## Operation
- Debounce path:
  - `btn` passes through a 2-flop synchroniser.
  - A counter increments while the synchronised level differs from the debounced level, and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - A rising edge of the debounced level forms a one-cycle `press`.
- The FSM has three states:
  - IDLE: `dice` holds its value and `busy`=0. On `press`, go to ANIM and clear the step counters.
  - ANIM: `dice` advances 1→2→…→6→1 at the end of every ANIM_STEP_CYCLES-cycle step. After ANIM_STEPS steps, go to REDUCE and latch `acc` ← `rnd` on that same edge.
  - REDUCE: each cycle, if `acc` ≥ 6 then `acc` ← `acc` − 6. Otherwise `dice` ← `acc` + 1, `done` pulses, and the FSM returns to IDLE.
- The result equals `(rnd mod 6) + 1` for the latched byte. `rnd` changes after the latch are ignored.
- `press` during ANIM or REDUCE is ignored and is not queued. Holding the button yields exactly one roll; a new roll needs a release (debounced) followed by a press.
- Reset values:
  - state IDLE, `dice`=1, `busy`=0, `done`=0, `acc`=0
  - debounced level 0, counters 0
  - `seg`=7'b0000110 (face 1)
- Reset asserted in any state returns to those values on the next edge. An in-flight roll is discarded with no `done`.
- If the button is held through reset, one roll starts after the debounce time.

## Timing
- Press to `busy`:
  - `btn` stably high, first sampled on edge 0.
  - Debounced level rises on edge DEBOUNCE_CYCLES+2.
  - `busy` rises on edge DEBOUNCE_CYCLES+3.
- ANIM lasts exactly ANIM_STEPS×ANIM_STEP_CYCLES cycles.
- REDUCE lasts floor(`acc`/6)+1 cycles: minimum 1 (`rnd` < 6), maximum 43 (`rnd`=255).
- `dice` update, `done` high and `busy` low all occur on the same edge that exits REDUCE.
- `done` is exactly one cycle wide.
- All outputs are registered; nothing is combinational from the inputs.

## Configuration
- `DICE_SEG_EN` defined: the `seg` port exists. It is registered and updated on the same edge as `dice`.
- `seg` encodings, faces 1..6:
  - 1 = 0000110
  - 2 = 1011011
  - 3 = 1001111
  - 4 = 1100110
  - 5 = 1101101
  - 6 = 1111101
- `DICE_SEG_EN` undefined: no `seg` port and no decoder logic. All other behaviour is identical.

## Structure
- Package `dice_pkg` holds:
  - the state enum (IDLE, ANIM, REDUCE)
  - `FACE_MIN`=1, `FACE_MAX`=6
  - the six segment constants
- Sub-module `btn_debounce` (parameter DEBOUNCE_CYCLES; ports `clk`, `rst`, `btn`, `level`, `rise`) contains the synchroniser, counter and edge detector.
- The FSM, animation counters, reducer and segment register live in `dice_roller`.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, ANIM_STEPS=3, ANIM_STEP_CYCLES=2.
- Reset: hold `rst` 3 cycles → `dice`=1, `busy`=0, `done`=0, `seg`=0000110.
- Clean press, `rnd`=255 throughout:
  - `busy` rises 7 cycles after `btn` first sampled high.
  - `dice` steps 2, 3, 4 during ANIM.
  - REDUCE lasts 43 cycles, then `dice`=4, `done`=1 for one cycle, `seg`=1100110.
- Mod-6 boundary cases:
  - `rnd`=0 → `dice`=1 after 1 REDUCE cycle.
  - `rnd`=5 → `dice`=6 after 1 REDUCE cycle.
  - `rnd`=6 → `dice`=1 after 2 REDUCE cycles.
- Latch point: `rnd` switches 17→200 one cycle after REDUCE is entered → `dice`=6 (17 mod 6 = 5, +1); the later 200 is ignored.
- Bounce and re-press:
  - `btn` toggling every 2 cycles for 40 cycles → no `busy`.
  - A second clean press during ANIM → exactly one `done`.
- Reset mid-REDUCE (`rnd`=255, `rst` on the 10th REDUCE cycle) → next edge `dice`=1, `busy`=0, and `done` never pulses.
